// File: rtl/random_design_bist_ctrl.sv
// Built-in stimulus/response controller: drives reset and LFSR vectors into a design
// under test and compacts its responses into a MISR signature compared with a golden word.
module random_design_bist_ctrl #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_VECTORS = 1000,
  parameter int               HOLD_CYCLES = 2,
  parameter int               RST_CYCLES  = 2,
  parameter logic [WIDTH-1:0] LFSR_SEED   = 32'h0000_0001,
  parameter logic [WIDTH-1:0] LFSR_POLY   = 32'h8020_0003,
  parameter logic [WIDTH-1:0] DIRECTED    = 32'hABCD_EFAB,
  parameter logic [WIDTH-1:0] GOLDEN_SIG  = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_rst,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      vec_count
);

  localparam int MAX_CYC = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int VIDX_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [VIDX_W-1:0] VEC_LAST  = (NUM_VECTORS > 0) ? VIDX_W'(NUM_VECTORS - 1) : '0;
  localparam logic [WIDTH-1:0]  SEED_EFF  = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST1   = 3'd1,
    S_GAP1   = 3'd2,
    S_RUN    = 3'd3,
    S_RST2   = 3'd4,
    S_GAP2   = 3'd5,
    S_DIR    = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VIDX_W-1:0] vidx_q, vidx_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  sig_q, sig_d;
  logic [15:0]       vec_count_q, vec_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              dut_rst_q, dut_rst_d;
  logic [WIDTH-1:0]  dut_in_q, dut_in_d;
  logic [WIDTH-1:0]  lfsr_next;
  logic [WIDTH-1:0]  sig_next;
  logic              sample;

  // Shared right-shift Galois step for both the stimulus LFSR and the MISR.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  assign lfsr_next = galois_step(lfsr_q);
  assign sig_next  = galois_step(sig_q) ^ dut_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vidx_d      = vidx_q;
    lfsr_d      = lfsr_q;
    vec_count_d = vec_count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    dut_rst_d   = dut_rst_q;
    dut_in_d    = dut_in_q;
    sample      = 1'b0;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d     = S_RST1;
          cnt_d       = '0;
          vidx_d      = '0;
          lfsr_d      = SEED_EFF;
          vec_count_d = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          dut_rst_d   = 1'b1;
          dut_in_d    = '0;
        end else begin
          state_d   = S_IDLE;
          dut_rst_d = 1'b1;
          dut_in_d  = '0;
        end
      end
      S_RST1: begin
        if (cnt_q == RST_LAST) begin
          sample    = 1'b1;
          state_d   = S_GAP1;
          cnt_d     = '0;
          dut_rst_d = 1'b0;
          dut_in_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP1: begin
        cnt_d = '0;
        if (NUM_VECTORS == 0) begin
          state_d   = S_RST2;
          dut_rst_d = 1'b1;
          dut_in_d  = '0;
        end else begin
          state_d  = S_RUN;
          vidx_d   = '0;
          lfsr_d   = lfsr_next;
          dut_in_d = lfsr_next;
        end
      end
      S_RUN: begin
        if (cnt_q == HOLD_LAST) begin
          sample      = 1'b1;
          cnt_d       = '0;
          vec_count_d = (vec_count_q == 16'hFFFF) ? vec_count_q : vec_count_q + 16'd1;
          if (vidx_q == VEC_LAST) begin
            state_d   = S_RST2;
            dut_rst_d = 1'b1;
            dut_in_d  = '0;
          end else begin
            vidx_d   = vidx_q + 1'b1;
            lfsr_d   = lfsr_next;
            dut_in_d = lfsr_next;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RST2: begin
        if (cnt_q == RST_LAST) begin
          sample    = 1'b1;
          state_d   = S_GAP2;
          cnt_d     = '0;
          dut_rst_d = 1'b0;
          dut_in_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP2: begin
        state_d  = S_DIR;
        cnt_d    = '0;
        dut_in_d = DIRECTED;
      end
      S_DIR: begin
        if (cnt_q == HOLD_LAST) begin
          // The verdict uses the signature including this final sample.
          sample   = 1'b1;
          state_d  = S_FINISH;
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = (sig_next == GOLDEN_SIG);
          dut_in_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sig_d = sig_q;
    if ((state_q == S_IDLE || state_q == S_FINISH) && start) begin
      sig_d = '0;
    end else if (sample) begin
      sig_d = sig_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vidx_q      <= '0;
      lfsr_q      <= SEED_EFF;
      sig_q       <= '0;
      vec_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      dut_rst_q   <= 1'b1;
      dut_in_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vidx_q      <= vidx_d;
      lfsr_q      <= lfsr_d;
      sig_q       <= sig_d;
      vec_count_q <= vec_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      dut_rst_q   <= dut_rst_d;
      dut_in_q    <= dut_in_d;
    end
  end

  assign dut_rst   = dut_rst_q;
  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_random_design_bist_ctrl.sv
// Directed bench for random_design_bist_ctrl: loopback runs on three instances (main,
// wrong golden, zero vectors) with a vector scoreboard and an independent signature model.
module tb_random_design_bist_ctrl;

  localparam int          W    = 32;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] DIRV = 32'hABCD_EFAB;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Loopback signature: RST1 sample, n vectors (optionally bit0-flipped at fault_idx), RST2, directed.
  function automatic logic [31:0] model_sig(input int n, input int fault_idx);
    logic [31:0] l, s, v;
    l = 32'h1;
    s = 32'h0;
    s = step(s);
    for (int i = 0; i < n; i++) begin
      l = step(l);
      v = l;
      if (i == fault_idx) v[0] = ~v[0];
      s = step(s) ^ v;
    end
    s = step(s);
    s = step(s) ^ DIRV;
    return s;
  endfunction

  localparam logic [31:0] SIG4 = model_sig(4, -1);
  localparam logic [31:0] SIG0 = model_sig(0, -1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic fault_en = 1'b0;

  logic          dut_rst_a, dut_rst_b, dut_rst_c;
  logic [W-1:0]  dut_in_a, dut_in_b, dut_in_c;
  logic [W-1:0]  dut_out_a, dut_out_b, dut_out_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;
  logic          pass_a, pass_b, pass_c;
  logic [W-1:0]  sig_a, sig_b, sig_c;
  logic [15:0]   vc_a, vc_b, vc_c;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_in = '0;

  always #5 clk = ~clk;

  assign dut_out_a = dut_in_a ^ {{(W-1){1'b0}}, (fault_en && vc_a == 16'd1)};
  assign dut_out_b = dut_in_b;
  assign dut_out_c = dut_in_c;

  random_design_bist_ctrl #(.WIDTH(W), .NUM_VECTORS(4), .HOLD_CYCLES(2), .RST_CYCLES(2),
    .GOLDEN_SIG(SIG4)) u_a (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst_a), .dut_in(dut_in_a),
    .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .vec_count(vc_a));

  random_design_bist_ctrl #(.WIDTH(W), .NUM_VECTORS(4), .HOLD_CYCLES(2), .RST_CYCLES(2),
    .GOLDEN_SIG(SIG4 ^ 32'h1)) u_b (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst_b), .dut_in(dut_in_b),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .vec_count(vc_b));

  random_design_bist_ctrl #(.WIDTH(W), .NUM_VECTORS(0), .HOLD_CYCLES(2), .RST_CYCLES(2),
    .GOLDEN_SIG(SIG0)) u_c (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst_c), .dut_in(dut_in_c),
    .dut_out(dut_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .vec_count(vc_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Each new non-zero stimulus word on u_a is checked against the next expected vector.
  always @(negedge clk) begin
    if (dut_in_a != last_in && dut_in_a != '0) begin
      if (exp_q.size() == 0) check("unexpected_vector", dut_in_a, 32'h0);
      else check("dut_in_seq", dut_in_a, exp_q.pop_front());
    end
    last_in = dut_in_a;
  end

  task automatic push_expected();
    logic [31:0] l;
    l = 32'h1;
    for (int i = 0; i < 4; i++) begin
      l = step(l);
      exp_q.push_back(l);
    end
    exp_q.push_back(DIRV);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at the negedge of the first busy cycle (k0 cycles already elapsed).
  task automatic wait_done(input int k0, output int k_done, output int c_done,
                           output logic [7:0] trace);
    int k;
    k = k0;
    c_done = -1;
    trace = '0;
    while (!done_a && k < 200) begin
      if (k < 8) trace[k] = dut_rst_c;
      if (done_c && c_done < 0) c_done = k;
      @(negedge clk);
      k++;
    end
    if (!done_a) check("done_timeout", 32'(k), 32'd16);
    k_done = k;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_dut_rst"}, 32'(dut_rst_a), 32'd1);
    check({pfx, "_dut_in"}, dut_in_a, 32'h0);
    check({pfx, "_busy"}, 32'(busy_a), 32'd0);
    check({pfx, "_done"}, 32'(done_a), 32'd0);
    check({pfx, "_pass"}, 32'(pass_a), 32'd0);
    check({pfx, "_sig"}, sig_a, 32'h0);
    check({pfx, "_vec_count"}, 32'(vc_a), 32'd0);
  endtask

  initial begin
    int kd, cd;
    logic [7:0] tr;

    // Reset with start asserted throughout: start must be ignored.
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_during_rst_busy", 32'(busy_a), 32'd0);

    // Clean loopback run on all three instances.
    push_expected();
    pulse_start();
    check("run1_busy", 32'(busy_a), 32'd1);
    wait_done(0, kd, cd, tr);
    check("run1_latency", 32'(kd), 32'd16);
    check("run1_sig", sig_a, SIG4);
    check("run1_pass", 32'(pass_a), 32'd1);
    check("run1_vec_count", 32'(vc_a), 32'd4);
    check("run1_busy_low", 32'(busy_a), 32'd0);
    check("run1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("badgold_sig", sig_b, SIG4);
    check("badgold_pass", 32'(pass_b), 32'd0);
    check("nv0_latency", 32'(cd), 32'd8);
    check("nv0_dut_rst_trace", 32'(tr), 32'h1B);
    check("nv0_sig", sig_c, SIG0);
    check("nv0_pass", 32'(pass_c), 32'd1);
    check("nv0_vec_count", 32'(vc_c), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_dut_rst", 32'(dut_rst_a), 32'd1);
    check("done_sticky", 32'(done_a), 32'd1);

    // Fault on vector 2: response bit 0 flipped.
    fault_en = 1'b1;
    push_expected();
    pulse_start();
    check("fault_done_cleared", 32'(done_a), 32'd0);
    check("fault_pass_cleared", 32'(pass_a), 32'd0);
    wait_done(0, kd, cd, tr);
    fault_en = 1'b0;
    check("fault_sig_model", sig_a, model_sig(4, 1));
    check("fault_sig_differs", 32'(sig_a !== SIG4), 32'd1);
    check("fault_pass", 32'(pass_a), 32'd0);

    // Extra start pulse mid-run must change nothing.
    push_expected();
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(5, kd, cd, tr);
    check("midstart_latency", 32'(kd), 32'd16);
    check("midstart_sig", sig_a, SIG4);
    check("midstart_pass", 32'(pass_a), 32'd1);
    check("midstart_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during vector 2.
    push_expected();
    pulse_start();
    for (int i = 0; i < 50 && vc_a != 16'd1; i++) @(negedge clk);
    check("reach_vector2", 32'(vc_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    exp_q.delete();

    // Fresh run after the abort gives a clean signature.
    push_expected();
    pulse_start();
    wait_done(0, kd, cd, tr);
    check("rerun_latency", 32'(kd), 32'd16);
    check("rerun_sig", sig_a, SIG4);
    check("rerun_pass", 32'(pass_a), 32'd1);
    check("rerun_vec_count", 32'(vc_a), 32'd4);
    check("rerun_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
